// File: rtl/scope_capture.sv
// Triggered acquisition engine for the scope sample buffer. Samples an unsigned input into a
// circular RAM, keeps a pre-trigger window, triggers on level/slope (or auto-triggers after a
// timeout), then freezes the record for the display reader until a frame-done pulse re-arms.
// The reader addresses samples by logical index, 0 being the oldest pre-trigger sample.
module scope_capture #(
  parameter int unsigned DEPTH   = 1280,
  parameter int unsigned AW      = 11,
  parameter int unsigned DW      = 16,
  parameter int unsigned PRETRIG = 256,
  parameter int unsigned AUTO_TO = 4096
) (
  input  logic          CLOCK_50,
  input  logic          iRST_n,
  input  logic [DW-1:0] signal,
  input  logic          run,
  input  logic [7:0]    decim,
  input  logic [DW-1:0] trig_level,
  input  logic          trig_slope,
  input  logic          auto_en,
  input  logic          frame_done,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          ready,
  output logic          trig_auto,
  output logic [15:0]   acq_count,
  output logic [2:0]    state_dbg
);

  localparam int unsigned CntMax = (AUTO_TO > DEPTH) ? AUTO_TO : DEPTH;
  localparam int unsigned CW     = $clog2(CntMax + 1);

  localparam logic [CW-1:0] PrefillLast = CW'(PRETRIG - 1);
  localparam logic [CW-1:0] AutoLast    = CW'(AUTO_TO - 1);
  localparam logic [CW-1:0] PostLast    = CW'(DEPTH - PRETRIG - 2);
  localparam logic [AW:0]   DepthW      = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   PretrigW    = (AW + 1)'(PRETRIG);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StPrefill = 3'd1,
    StArmed   = 3'd2,
    StPost    = 3'd3,
    StDone    = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [7:0]    dec_cnt_q, dec_cnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] start_ptr_q, start_ptr_d;
  logic [DW-1:0] prev_q, prev_d;
  logic          prev_valid_q, prev_valid_d;
  logic          trig_auto_q, trig_auto_d;
  logic [15:0]   acq_count_q, acq_count_d;
  logic          ready_q, ready_d;
  logic [DW-1:0] rd_data_q, rd_data_d;

  logic [DW-1:0] mem [DEPTH];

  logic          strobe;
  logic          mem_we;
  logic          rise_hit;
  logic          fall_hit;
  logic          real_trig;
  logic          auto_trig;
  logic          arm_start;
  logic          enter_done;
  logic [AW:0]   wr_inc;
  logic [AW:0]   start_diff;
  logic [AW:0]   rd_sum;
  logic [AW-1:0] wr_next;
  logic [AW-1:0] start_next;
  logic [AW-1:0] rd_idx;

  // Sample strobe, trigger qualification and the mod-DEPTH pointer arithmetic.
  always_comb begin
    strobe    = (dec_cnt_q == decim);
    mem_we    = strobe &&
                ((state_q == StPrefill) || (state_q == StArmed) || (state_q == StPost));
    rise_hit  = (prev_q < trig_level) && (signal >= trig_level);
    fall_hit  = (prev_q > trig_level) && (signal <= trig_level);
    real_trig = (state_q == StArmed) && run && strobe && prev_valid_q &&
                (trig_slope ? fall_hit : rise_hit);
    // A real trigger on the same strobe takes precedence over the timeout.
    auto_trig = (state_q == StArmed) && run && strobe && auto_en &&
                (cnt_q == AutoLast) && !real_trig;

    wr_inc     = {1'b0, wr_ptr_q} + (AW + 1)'(1);
    wr_next    = (wr_inc >= DepthW) ? AW'(wr_inc - DepthW) : wr_inc[AW-1:0];
    // Top bit of the difference is the borrow; fold negative results back into range.
    start_diff = {1'b0, wr_ptr_q} - PretrigW;
    start_next = start_diff[AW] ? AW'(start_diff + DepthW) : start_diff[AW-1:0];
    rd_sum     = {1'b0, start_ptr_q} + {1'b0, rd_addr};
    rd_idx     = (rd_sum >= DepthW) ? AW'(rd_sum - DepthW) : rd_sum[AW-1:0];
  end

  // FSM state register.
  always_ff @(posedge CLOCK_50 or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (run) state_d = StPrefill;
      end
      StPrefill: begin
        if (!run) begin
          state_d = StIdle;
        end else if (strobe && (cnt_q == PrefillLast)) begin
          state_d = StArmed;
        end
      end
      StArmed: begin
        if (!run) begin
          state_d = StIdle;
        end else if (real_trig || auto_trig) begin
          state_d = StPost;
        end
      end
      StPost: begin
        // The record always completes once triggered, whatever run does.
        if (strobe && (cnt_q == PostLast)) state_d = StDone;
      end
      StDone: begin
        if (frame_done && run) state_d = StPrefill;
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: counters, pointers, trigger bookkeeping and the read port.
  always_comb begin
    dec_cnt_d    = strobe ? 8'd0 : dec_cnt_q + 8'd1;
    cnt_d        = cnt_q;
    wr_ptr_d     = wr_ptr_q;
    start_ptr_d  = start_ptr_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    trig_auto_d  = trig_auto_q;
    acq_count_d  = acq_count_q;
    arm_start    = (state_d == StPrefill) && (state_q != StPrefill);
    enter_done   = (state_d == StDone) && (state_q != StDone);

    if (mem_we) begin
      wr_ptr_d     = wr_next;
      prev_d       = signal;
      prev_valid_d = 1'b1;
      // Saturate in ARMED so a late auto_en still fires on the next strobe.
      if (!((state_q == StArmed) && (cnt_q == AutoLast))) cnt_d = cnt_q + CW'(1);
    end

    if (real_trig || auto_trig) begin
      start_ptr_d = start_next;
      trig_auto_d = auto_trig;
    end

    // Every phase change restarts the per-phase strobe count.
    if (state_d != state_q) cnt_d = '0;

    if (arm_start) begin
      dec_cnt_d    = 8'd0;
      wr_ptr_d     = '0;
      prev_valid_d = 1'b0;
      trig_auto_d  = 1'b0;
    end

    if (enter_done) acq_count_d = acq_count_q + 16'd1;

    ready_d   = (state_d == StDone);
    rd_data_d = ({1'b0, rd_addr} >= DepthW) ? '0 : mem[rd_idx];
  end

  // Datapath registers.
  always_ff @(posedge CLOCK_50 or negedge iRST_n) begin
    if (!iRST_n) begin
      dec_cnt_q    <= '0;
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      start_ptr_q  <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      trig_auto_q  <= 1'b0;
      acq_count_q  <= '0;
      ready_q      <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      dec_cnt_q    <= dec_cnt_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      start_ptr_q  <= start_ptr_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      trig_auto_q  <= trig_auto_d;
      acq_count_q  <= acq_count_d;
      ready_q      <= ready_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // Sample RAM write port; contents are deliberately not reset.
  always_ff @(posedge CLOCK_50) begin
    if (mem_we) mem[wr_ptr_q] <= signal;
  end

  // FSM outputs.
  always_comb begin
    rd_data   = rd_data_q;
    ready     = ready_q;
    trig_auto = trig_auto_q;
    acq_count = acq_count_q;
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_scope_capture.sv
// Self-checking bench for scope_capture: drives ramp / square / constant inputs, waits for a
// complete record and compares logical reads through a scoreboard queue.
module tb_scope_capture;

  typedef enum int {ModeHold, ModeRamp, ModeSquare} mode_e;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] sig;
  logic        run;
  logic [7:0]  decim;
  logic [15:0] trig_level;
  logic        trig_slope;
  logic        auto_en;
  logic        frame_done;
  logic [10:0] rd_addr;
  logic [15:0] rd_data;
  logic        ready;
  logic        trig_auto;
  logic [15:0] acq_count;
  logic [2:0]  state_dbg;

  mode_e       mode;
  int          phase;
  int          checks;
  int          errors;
  logic [15:0] exp_q[$];

  scope_capture dut (
    .CLOCK_50  (clk),
    .iRST_n    (rst_n),
    .signal    (sig),
    .run       (run),
    .decim     (decim),
    .trig_level(trig_level),
    .trig_slope(trig_slope),
    .auto_en   (auto_en),
    .frame_done(frame_done),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .ready     (ready),
    .trig_auto (trig_auto),
    .acq_count (acq_count),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change 1ns after the edge, outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
    case (mode)
      ModeRamp:   sig = sig + 16'd1;
      ModeSquare: begin
        phase = phase + 1;
        sig   = ((phase % 64) < 32) ? 16'hF000 : 16'h1000;
      end
      default: ;
    endcase
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    run        = 1'b0;
    frame_done = 1'b0;
    mode       = ModeHold;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Raise run; the first PREFILL strobe then sees 'first' and the pattern advances per clock.
  task automatic start_acq(input mode_e m, input logic [15:0] first);
    run = 1'b1;
    step();
    sig   = first;
    phase = 0;
    mode  = m;
  endtask

  task automatic pulse_fd();
    frame_done = 1'b1;
    step();
    frame_done = 1'b0;
  endtask

  task automatic wait_ready(input string tag, input int max, output int n);
    n = 0;
    while (!ready && (n < max)) begin
      step();
      n++;
    end
    check_eq(tag, {31'd0, ready}, 32'd1);
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, input int max);
    int n;
    n = 0;
    while ((state_dbg != s) && (n < max)) begin
      step();
      n++;
    end
    check_eq(tag, {29'd0, state_dbg}, {29'd0, s});
  endtask

  // Scoreboard: expected value queued with the address, popped when rd_data appears.
  task automatic do_read(input int a, input logic [15:0] exp);
    rd_addr = 11'(a);
    exp_q.push_back(exp);
    step();
    check_eq($sformatf("rd[%0d]", a), {16'd0, rd_data}, {16'd0, exp_q.pop_front()});
  endtask

  initial begin
    int n;
    int seen;
    checks     = 0;
    errors     = 0;
    sig        = 16'd0;
    decim      = 8'd0;
    trig_level = 16'd1000;
    trig_slope = 1'b0;
    auto_en    = 1'b0;
    rd_addr    = 11'd0;
    phase      = 0;
    do_reset();

    // Reset state
    check_eq("rst_ready", {31'd0, ready}, 32'd0);
    check_eq("rst_trig_auto", {31'd0, trig_auto}, 32'd0);
    check_eq("rst_rd_data", {16'd0, rd_data}, 32'd0);
    check_eq("rst_acq_count", {16'd0, acq_count}, 32'd0);
    check_eq("rst_state", {29'd0, state_dbg}, 32'd0);

    // 1. Rising trigger on a per-clock ramp: trigger value 1000 lands at address 1000
    start_acq(ModeRamp, 16'd0);
    wait_ready("t1_ready", 5000, n);
    check_eq("t1_ready_latency", n, 32'd2024);
    check_eq("t1_state", {29'd0, state_dbg}, 32'd4);
    check_eq("t1_trig_auto", {31'd0, trig_auto}, 32'd0);
    check_eq("t1_acq_count", {16'd0, acq_count}, 32'd1);
    do_read(0, 16'd744);
    do_read(1, 16'd745);
    do_read(256, 16'd1000);
    do_read(255, 16'd999);
    do_read(1279, 16'd2023);
    do_read(1280, 16'd0);
    do_read(2047, 16'd0);

    // 2. Falling trigger on a 64-clock square wave
    do_reset();
    trig_slope = 1'b1;
    trig_level = 16'h8000;
    start_acq(ModeSquare, 16'hF000);
    wait_ready("t2_ready", 5000, n);
    do_read(256, 16'h1000);
    do_read(255, 16'hF000);
    do_read(0, 16'h1000);
    do_read(1279, 16'hF000);
    check_eq("t2_trig_auto", {31'd0, trig_auto}, 32'd0);

    // 3. Auto trigger on a constant input, then re-arm and freeze
    do_reset();
    trig_slope = 1'b0;
    trig_level = 16'd1000;
    auto_en    = 1'b1;
    sig        = 16'h4000;
    start_acq(ModeHold, 16'h4000);
    wait_ready("t3_ready", 8000, n);
    check_eq("t3_ready_latency", n, 32'd5375);
    check_eq("t3_trig_auto", {31'd0, trig_auto}, 32'd1);
    do_read(300, 16'h4000);
    sig = 16'h5000;
    pulse_fd();
    check_eq("t5_rearm_ready", {31'd0, ready}, 32'd0);
    check_eq("t5_rearm_state", {29'd0, state_dbg}, 32'd1);
    check_eq("t5_rearm_trig_auto", {31'd0, trig_auto}, 32'd0);
    wait_ready("t5_ready2", 8000, n);
    check_eq("t5_ready2_latency", n, 32'd5375);
    check_eq("t5_acq_count", {16'd0, acq_count}, 32'd2);
    run = 1'b0;
    sig = 16'h6000;
    for (int i = 0; i < 3; i++) begin
      pulse_fd();
      step();
      check_eq($sformatf("t5_frozen_ready%0d", i), {31'd0, ready}, 32'd1);
      check_eq($sformatf("t5_frozen_state%0d", i), {29'd0, state_dbg}, 32'd4);
    end
    check_eq("t5_frozen_acq", {16'd0, acq_count}, 32'd2);
    do_read(0, 16'h5000);
    do_read(1279, 16'h5000);

    // 3b. No auto trigger: stays armed; a frame_done pulse while armed is ignored
    do_reset();
    auto_en = 1'b0;
    sig     = 16'h4000;
    start_acq(ModeHold, 16'h4000);
    seen = 0;
    for (int i = 0; i < 6000; i++) begin
      step();
      if (ready) seen++;
    end
    check_eq("t3b_never_ready", seen, 32'd0);
    check_eq("t3b_state", {29'd0, state_dbg}, 32'd2);
    pulse_fd();
    step();
    check_eq("t5_armed_fd_state", {29'd0, state_dbg}, 32'd2);
    check_eq("t5_armed_fd_ready", {31'd0, ready}, 32'd0);

    // 4. Decimation by 4: strobes on ramp values 3+4k, trigger on 2003
    do_reset();
    decim      = 8'd3;
    trig_level = 16'd2000;
    start_acq(ModeRamp, 16'd0);
    wait_ready("t4_ready", 10000, n);
    do_read(0, 16'd979);
    do_read(1, 16'd983);
    do_read(255, 16'd1999);
    do_read(256, 16'd2003);
    do_read(1279, 16'd6095);

    // 6. Wrapped record: trigger value 1380 is written at physical address 100
    do_reset();
    decim      = 8'd0;
    trig_level = 16'd1380;
    start_acq(ModeRamp, 16'd0);
    wait_ready("t6_ready", 5000, n);
    do_read(0, 16'd1124);
    do_read(155, 16'd1279);
    do_read(156, 16'd1280);  // physical address 0
    do_read(256, 16'd1380);
    do_read(1279, 16'd2403);

    // 6b. Re-arm, then drop reset in the middle of POST
    trig_level = 16'd1000;
    pulse_fd();
    sig  = 16'd0;
    mode = ModeRamp;
    wait_state("t6b_post", 3'd3, 3000);
    for (int i = 0; i < 100; i++) step();
    check_eq("t6b_post_still", {29'd0, state_dbg}, 32'd3);
    do_read(5, 16'd749);
    check_eq("t6b_acq_before", {16'd0, acq_count}, 32'd1);
    #2;
    rst_n = 1'b0;
    run   = 1'b0;
    #1;
    check_eq("t6b_rst_ready", {31'd0, ready}, 32'd0);
    check_eq("t6b_rst_rd_data", {16'd0, rd_data}, 32'd0);
    check_eq("t6b_rst_acq", {16'd0, acq_count}, 32'd0);
    check_eq("t6b_rst_trig_auto", {31'd0, trig_auto}, 32'd0);
    check_eq("t6b_rst_state", {29'd0, state_dbg}, 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check_eq("t6b_idle_hold", {29'd0, state_dbg}, 32'd0);
    run = 1'b1;
    step();
    check_eq("t6b_restart", {29'd0, state_dbg}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
